mreza_upravljac: RTL and testbench
==================================

# mreza_upravljac

Sequencer in front of the combinational mine/rock classifier `Neural_net`. It assembles one 960-bit sample from 60 serially delivered 16-bit words over a valid/ready handshake and drives the assembled vector to `Neural_net.uzorak`. It then waits a fixed settle time for the two-layer combinational datapath, captures `indikator_1`/`indikator_2` into registers and presents them as a held result with its own valid/ready handshake. It also counts completed classifications.

## Interface
Parameters:
- `N_RIJECI`, 60: number of 16-bit words per sample; `N_RIJECI*SIRINA` must equal 960.
- `SIRINA`, 16: word width in bits.
- `SETTLE`, 4: cycles allowed for `Neural_net` to settle.
  - Range 1..15.
  - Sized to cover the multiplier/adder depth at the target clock.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset; highest priority.
- `prekid` in 1: synchronous abort; discards the sample in progress.
- `in_podatak` in 16: sample word.
- `in_valid` in 1: the word on `in_podatak` is valid.
- `in_ready` out 1: block accepts a word this cycle.
- `uzorak_o` out 960: assembled sample, wired to `Neural_net.uzorak`.
- `ind_1_i`, `ind_2_i` in 1 each: from `Neural_net.indikator_1` and `Neural_net.indikator_2`.
- `rez_valid` out 1: result held and valid.
- `rez_ready` in 1: consumer takes the result.
- `indikator_1`, `indikator_2` out 1 each: registered result bits.
- `zauzet` out 1: high when not in LOAD, or when in LOAD with `indeks`≠0.
- `broj_uzoraka` out 16: completed-result counter; wraps 0xFFFF→0x0000.

## Operation
- Word order: the word accepted with index k (0..59) is written to `uzorak_o[16k+15:16k]`.
  - Only that slice changes; other slices keep prior contents.
- Accept event: `in_valid && in_ready` at a rising edge.
- States: LOAD, SETTLE, DONE.
- LOAD
  - `in_ready`=1.
  - Each accept writes the word at `indeks` and increments `indeks`.
  - Accept at `indeks`=59: `indeks`→0, settle counter `cnt`→`SETTLE`, next state SETTLE.
- SETTLE
  - `in_ready`=0; `uzorak_o` is frozen.
  - `cnt` decrements every cycle.
  - On the edge where `cnt`==1: `indikator_1`←`ind_1_i`, `indikator_2`←`ind_2_i`, `rez_valid`←1, next state DONE.
- DONE
  - `in_ready`=0.
  - `rez_valid`, `indikator_1`, `indikator_2` and `uzorak_o` are held stable until the handshake.
  - Handshake `rez_valid && rez_ready`: `rez_valid`←0, `broj_uzoraka`+1, next state LOAD.
- `prekid` (priority below `rst`, above everything else)
  - In any state: next state LOAD, `indeks`←0, `cnt`←0, `rez_valid`←0.
  - `broj_uzoraka` and `indikator_*` are unchanged.
  - A word presented in the same cycle as `prekid` is not accepted and not written, even though `in_ready`=1.
  - `prekid` in DONE discards the result with no count increment.
- `rst`: every register goes to its reset value. `rst` mid-LOAD or mid-SETTLE drops the partial sample.
- `in_valid` while `in_ready`=0: ignored. The source must hold the word (standard valid/ready).
- `in_podatak` is not interpreted. Fixed-point format is the responsibility of `Neural_net`.

## Timing
- Reset values:
  - state LOAD, `indeks`=0, `cnt`=0
  - `in_ready`=1, `zauzet`=0
  - `rez_valid`=0, `indikator_1`=0, `indikator_2`=0
  - `uzorak_o`=0, `broj_uzoraka`=0
- `in_ready` and `rez_valid` are derived from state and registers only. There is no combinational path from `in_valid` or `rez_ready`.
- Latency: `rez_valid` rises exactly `SETTLE` edges after the edge accepting word 59. The capture edge samples `ind_*_i` driven by the final `uzorak_o`.
- Throughput with `in_valid` and `rez_ready` tied high: one result per 60+`SETTLE`+1 cycles. `in_ready` is low for `SETTLE`+1 consecutive cycles between samples.
- `in_podatak` may stall arbitrarily between words. There is no timeout.

## Test plan
- Reset, then 60 words with word k = 16'h0100+k, gap-free, and `rez_ready`=1:
  - `uzorak_o[15:0]`=16'h0100 and `uzorak_o[959:944]`=16'h013B.
  - `rez_valid` high exactly 4 cycles after the last accept, for 1 cycle.
  - `broj_uzoraka`=1.
- Model `ind_1_i`=1, `ind_2_i`=0 for the final vector; hold `rez_ready`=0 for 10 cycles:
  - `rez_valid` and `indikator_1`=1, `indikator_2`=0 stay stable for all 10 cycles.
  - `in_ready`=0 throughout.
  - Release `rez_ready` → `rez_valid` falls next edge; count increments once.
- Random `in_valid` gaps (~50%) over 3 samples: all 180 words land in the correct slices; `broj_uzoraka`=3; no word is lost or duplicated.
- `prekid` after word 30:
  - `indeks` returns to 0; next 60 words form a clean sample.
  - `prekid` during DONE: `rez_valid`→0, count unchanged.
- `rst` asserted in SETTLE with `cnt`=2: next cycle all outputs are at reset values and no `rez_valid` pulse appears.
- Preload `broj_uzoraka`=16'hFFFF via 65535 back-to-back results (or a force in the bench), complete one more result → 16'h0000.

Source files
------------

// File: rtl/mreza_upravljac.sv
// mreza_upravljac -- sequencer in front of the combinational Neural_net
// classifier. Collects N_RIJECI words of SIRINA bits over a valid/ready
// handshake into one sample vector, lets Neural_net settle for SETTLE cycles,
// captures both indicator bits and offers them as a held result with its own
// valid/ready handshake. Completed (handed-off) results are counted.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   prekid              synchronous abort of the sample/result in progress
//   in_podatak/in_valid/in_ready   word input handshake
//   uzorak_o            assembled sample, drives Neural_net.uzorak
//   ind_1_i, ind_2_i    Neural_net.indikator_1 / indikator_2
//   rez_valid/rez_ready result handshake
//   indikator_1/2       registered result bits
//   zauzet              busy: not in LOAD, or LOAD with a partial sample
//   broj_uzoraka        completed-result counter (wraps)
module mreza_upravljac #(
   parameter int N_RIJECI = 60,
   parameter int SIRINA   = 16,
   parameter int SETTLE   = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         prekid,
   input  logic [SIRINA-1:0]            in_podatak,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [N_RIJECI*SIRINA-1:0]   uzorak_o,
   input  logic                         ind_1_i,
   input  logic                         ind_2_i,
   output logic                         rez_valid,
   input  logic                         rez_ready,
   output logic                         indikator_1,
   output logic                         indikator_2,
   output logic                         zauzet,
   output logic [15:0]                  broj_uzoraka
);

   localparam int IW = $clog2(N_RIJECI);

   typedef enum logic [1:0] {
      S_LOAD,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t                       r_state;
   state_t                       w_next;
   logic [IW-1:0]                r_indeks;
   logic [3:0]                   r_cnt;
   logic [N_RIJECI*SIRINA-1:0]   r_uzorak;
   logic                         r_ind_1;
   logic                         r_ind_2;
   logic                         r_rez_valid;
   logic [15:0]                  r_broj_uzoraka;

   logic w_accept;
   logic w_last_word;
   logic w_capture;
   logic w_handshake;

   // A word presented together with prekid is never accepted.
   assign w_accept    = in_valid && (r_state == S_LOAD) && !prekid;
   assign w_last_word = (r_indeks == IW'(N_RIJECI - 1));
   assign w_capture   = (r_state == S_SETTLE) && (r_cnt == 4'd1);
   assign w_handshake = (r_state == S_DONE) && r_rez_valid && rez_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      if (prekid) begin
         w_next = S_LOAD;
      end else begin
         unique case (r_state)
            S_LOAD:   if (w_accept && w_last_word) w_next = S_SETTLE;
            S_SETTLE: if (w_capture)               w_next = S_DONE;
            S_DONE:   if (w_handshake)             w_next = S_LOAD;
            default:                               w_next = S_LOAD;
         endcase
      end
   end

   // Outputs derived from state/registers only
   always_comb begin
      in_ready = (r_state == S_LOAD);
      zauzet   = (r_state != S_LOAD) || (r_indeks != '0);
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_indeks       <= '0;
         r_cnt          <= '0;
         r_uzorak       <= '0;
         r_ind_1        <= 1'b0;
         r_ind_2        <= 1'b0;
         r_rez_valid    <= 1'b0;
         r_broj_uzoraka <= '0;
      end else if (prekid) begin
         r_indeks    <= '0;
         r_cnt       <= '0;
         r_rez_valid <= 1'b0;
      end else begin
         unique case (r_state)
            S_LOAD: begin
               if (w_accept) begin
                  r_uzorak[int'(r_indeks)*SIRINA +: SIRINA] <= in_podatak;
                  if (w_last_word) begin
                     r_indeks <= '0;
                     r_cnt    <= 4'(SETTLE);
                  end else begin
                     r_indeks <= r_indeks + 1'b1;
                  end
               end
            end
            S_SETTLE: begin
               r_cnt <= r_cnt - 1'b1;
               if (w_capture) begin
                  r_ind_1     <= ind_1_i;
                  r_ind_2     <= ind_2_i;
                  r_rez_valid <= 1'b1;
               end
            end
            S_DONE: begin
               if (w_handshake) begin
                  r_rez_valid    <= 1'b0;
                  r_broj_uzoraka <= r_broj_uzoraka + 1'b1;
               end
            end
            default: begin
               r_indeks <= '0;
            end
         endcase
      end
   end

   assign uzorak_o     = r_uzorak;
   assign rez_valid    = r_rez_valid;
   assign indikator_1  = r_ind_1;
   assign indikator_2  = r_ind_2;
   assign broj_uzoraka = r_broj_uzoraka;

endmodule

// File: tb/tb_mreza_upravljac.sv
// Self-checking bench for mreza_upravljac. A small stand-in for Neural_net
// derives the indicator inputs from the sample vector; expected results are
// queued when a full sample has been driven and checked on rez_valid.
module tb_mreza_upravljac;

   localparam int N = 60;
   localparam int W = 16;
   localparam int S = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          prekid;
   logic [W-1:0]  in_podatak;
   logic          in_valid;
   logic          in_ready;
   logic [N*W-1:0] uzorak_o;
   logic          ind_1_i;
   logic          ind_2_i;
   logic          rez_valid;
   logic          rez_ready;
   logic          indikator_1;
   logic          indikator_2;
   logic          zauzet;
   logic [15:0]   broj_uzoraka;

   always #5 clk = ~clk;

   // Neural_net stand-in: parity of the whole vector and the top bit.
   assign ind_1_i = ^uzorak_o;
   assign ind_2_i = uzorak_o[N*W-1];

   mreza_upravljac #(.N_RIJECI(N), .SIRINA(W), .SETTLE(S)) dut (
      .clk          (clk),
      .rst          (rst),
      .prekid       (prekid),
      .in_podatak   (in_podatak),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .uzorak_o     (uzorak_o),
      .ind_1_i      (ind_1_i),
      .ind_2_i      (ind_2_i),
      .rez_valid    (rez_valid),
      .rez_ready    (rez_ready),
      .indikator_1  (indikator_1),
      .indikator_2  (indikator_2),
      .zauzet       (zauzet),
      .broj_uzoraka (broj_uzoraka)
   );

   typedef struct packed {
      logic [N*W-1:0] vec;
      logic           i1;
      logic           i2;
   } exp_t;

   exp_t          sb[$];
   logic [N*W-1:0] shadow;
   logic [W-1:0]  wbuf [N];
   logic [15:0]   exp_cnt;
   int            n_checks;
   int            n_fail;

   // Drive one word; returns 1 time unit after the accepting edge.
   task automatic put_word(input logic [W-1:0] d, input int idx, input bit gaps);
      int t;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      in_valid   = 1'b1;
      in_podatak = d;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (t >= 20) begin
         n_fail++;
         $display("FAIL word_accept_timeout idx=%0d in_ready=%b required=1", idx, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      shadow[idx*W +: W] = d;
   endtask

   task automatic send_words(input int n, input bit gaps);
      for (int k = 0; k < n; k++) put_word(wbuf[k], k, gaps);
   endtask

   task automatic push_expected();
      exp_t e;
      e.vec = shadow;
      e.i1  = ^shadow;
      e.i2  = shadow[N*W-1];
      sb.push_back(e);
   endtask

   // Wait for a result, compare it, hold it for `hold` cycles, then take it.
   task automatic collect(input int hold);
      exp_t e;
      int   t;
      t = 0;
      while (!rez_valid && t < 40) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (!rez_valid) begin
         n_fail++;
         $display("FAIL rez_valid_timeout got=%b required=1", rez_valid);
      end
      e = sb.pop_front();
      n_checks++;
      if (uzorak_o !== e.vec) begin
         n_fail++;
         $display("FAIL sample_vector got_lo=%h required_lo=%h got_hi=%h required_hi=%h",
                  uzorak_o[63:0], e.vec[63:0], uzorak_o[N*W-1 -: 64], e.vec[N*W-1 -: 64]);
      end
      n_checks++;
      if ({indikator_1, indikator_2} !== {e.i1, e.i2}) begin
         n_fail++;
         $display("FAIL indicators got=%b%b required=%b%b", indikator_1, indikator_2, e.i1, e.i2);
      end
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         n_checks++;
         if ({rez_valid, indikator_1, indikator_2, in_ready} !== {1'b1, e.i1, e.i2, 1'b0}
             || uzorak_o !== e.vec) begin
            n_fail++;
            $display("FAIL hold_stable cyc=%0d got v/i1/i2/rdy=%b%b%b%b required=1%b%b0",
                     c, rez_valid, indikator_1, indikator_2, in_ready, e.i1, e.i2);
         end
      end
      @(negedge clk);
      rez_ready = 1'b1;
      @(posedge clk);
      #1;
      rez_ready = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      n_checks++;
      if (rez_valid !== 1'b0 || broj_uzoraka !== exp_cnt) begin
         n_fail++;
         $display("FAIL result_taken got valid=%b cnt=%h required valid=0 cnt=%h",
                  rez_valid, broj_uzoraka, exp_cnt);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      n_checks++;
      if ({in_ready, zauzet, rez_valid, indikator_1, indikator_2} !== 5'b10000
          || uzorak_o !== '0 || broj_uzoraka !== 16'h0000) begin
         n_fail++;
         $display("FAIL %s got rdy/busy/v/i1/i2=%b%b%b%b%b cnt=%h vec_lo=%h required 10000 cnt=0000 vec=0",
                  tag, in_ready, zauzet, rez_valid, indikator_1, indikator_2, broj_uzoraka, uzorak_o[63:0]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      shadow  = '0;
      exp_cnt = '0;
      check_reset_outputs("reset_values");
   endtask

   task automatic test_basic();
      exp_t e;
      for (int k = 0; k < N; k++) wbuf[k] = 16'h0100 + 16'(k);
      rez_ready = 1'b1;
      send_words(N, 1'b0);
      push_expected();
      for (int ed = 1; ed <= 5; ed++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (rez_valid !== (ed == S)) begin
            n_fail++;
            $display("FAIL latency edge=%0d rez_valid=%b required=%b", ed, rez_valid, ed == S);
         end
         if (ed == S) begin
            e = sb.pop_front();
            n_checks++;
            if (uzorak_o[15:0] !== 16'h0100 || uzorak_o[959:944] !== 16'h013B) begin
               n_fail++;
               $display("FAIL end_slices got=%h/%h required=0100/013B", uzorak_o[15:0], uzorak_o[959:944]);
            end
            n_checks++;
            if (uzorak_o !== e.vec || {indikator_1, indikator_2} !== {e.i1, e.i2}) begin
               n_fail++;
               $display("FAIL basic_result got i=%b%b required i=%b%b", indikator_1, indikator_2, e.i1, e.i2);
            end
         end
      end
      rez_ready = 1'b0;
      exp_cnt = 16'd1;
      n_checks++;
      if (broj_uzoraka !== 16'd1) begin
         n_fail++;
         $display("FAIL basic_count got=%h required=0001", broj_uzoraka);
      end
   endtask

   task automatic test_hold();
      for (int k = 0; k < N; k++) wbuf[k] = 16'h0000;
      wbuf[0] = 16'h0001;
      send_words(N, 1'b0);
      push_expected();
      collect(10);
      n_checks++;
      if ({indikator_1, indikator_2} !== 2'b10) begin
         n_fail++;
         $display("FAIL hold_indicators got=%b%b required=10", indikator_1, indikator_2);
      end
   endtask

   task automatic test_random_gaps();
      for (int s = 0; s < 3; s++) begin
         for (int k = 0; k < N; k++) wbuf[k] = 16'($urandom);
         send_words(N, 1'b1);
         push_expected();
         collect(0);
      end
   endtask

   task automatic test_prekid_load();
      for (int k = 0; k < N; k++) wbuf[k] = 16'h2000 + 16'(k);
      send_words(31, 1'b0);
      n_checks++;
      if (zauzet !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_partial got=%b required=1", zauzet);
      end
      @(negedge clk);
      prekid     = 1'b1;
      in_valid   = 1'b1;
      in_podatak = 16'hDEAD;
      @(posedge clk);
      #1;
      prekid   = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if ({zauzet, in_ready, rez_valid} !== 3'b010 || uzorak_o[31*W +: W] !== shadow[31*W +: W]) begin
         n_fail++;
         $display("FAIL prekid_load got busy/rdy/v=%b%b%b slice31=%h required 010 slice31=%h",
                  zauzet, in_ready, rez_valid, uzorak_o[31*W +: W], shadow[31*W +: W]);
      end
      for (int k = 0; k < N; k++) wbuf[k] = 16'h3000 + 16'(k);
      send_words(N, 1'b0);
      push_expected();
      collect(2);
   endtask

   task automatic test_prekid_done();
      exp_t e;
      int   t;
      for (int k = 0; k < N; k++) wbuf[k] = 16'h4000 + 16'(3 * k);
      send_words(N, 1'b0);
      push_expected();
      t = 0;
      while (!rez_valid && t < 40) begin
         @(negedge clk);
         t++;
      end
      e = sb.pop_front();
      n_checks++;
      if (rez_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL prekid_done_wait got=%b required=1", rez_valid);
      end
      @(negedge clk);
      prekid = 1'b1;
      @(posedge clk);
      #1;
      prekid = 1'b0;
      n_checks++;
      if ({rez_valid, in_ready} !== 2'b01 || broj_uzoraka !== exp_cnt
          || {indikator_1, indikator_2} !== {e.i1, e.i2}) begin
         n_fail++;
         $display("FAIL prekid_done got v/rdy=%b%b cnt=%h i=%b%b required 01 cnt=%h i=%b%b",
                  rez_valid, in_ready, broj_uzoraka, indikator_1, indikator_2, exp_cnt, e.i1, e.i2);
      end
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (rez_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL prekid_done_quiet rez_valid=%b required=0", rez_valid);
         end
      end
   endtask

   task automatic test_rst_settle();
      for (int k = 0; k < N; k++) wbuf[k] = 16'h5000 + 16'(k);
      send_words(N, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      shadow  = '0;
      exp_cnt = '0;
      check_reset_outputs("rst_in_settle");
      repeat (6) begin
         @(negedge clk);
         n_checks++;
         if (rez_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_pulse rez_valid=%b required=0", rez_valid);
         end
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force dut.r_broj_uzoraka = 16'hFFFF;
      @(negedge clk);
      release dut.r_broj_uzoraka;
      exp_cnt = 16'hFFFF;
      n_checks++;
      if (broj_uzoraka !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL preload got=%h required=FFFF", broj_uzoraka);
      end
      for (int k = 0; k < N; k++) wbuf[k] = 16'h6000 ^ 16'(k * 7);
      send_words(N, 1'b0);
      push_expected();
      collect(0);
      n_checks++;
      if (broj_uzoraka !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap got=%h required=0000", broj_uzoraka);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b1;
      prekid     = 1'b0;
      in_valid   = 1'b0;
      in_podatak = '0;
      rez_ready  = 1'b0;
      test_reset();
      test_basic();
      test_hold();
      test_random_gaps();
      test_prekid_load();
      test_prekid_done();
      test_rst_settle();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
